matmul_responder: RTL

- Responder end of the engine's module handshake (enable/RW/matDecide/fleg) for matrix multiply.
- The engine writes operand A (matDecide=0), then operand B (matDecide=1), then issues a read (RW=0).
- The block computes C = A×B with one sequential MAC per clock, returns C on dataOut and pulses fleg.
- Sits on the engine's toModuleBus/fromMultBus pair; one instance per multiply/scale unit.

---
 rtl/matmul_responder_if.sv | 50 +++++
 rtl/matmul_responder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/matmul_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : matmul_responder_if
//  Description : Handshake and data bus between the engine and one matrix
//                multiply responder. The engine drives enable/RW/matDecide
//                and the operand bus. The responder returns the product,
//                the fleg completion pulse and busy.
//  Ports       : none (signal bundle only)
//                enable     engine -> responder, level request
//                RW         engine -> responder, 1 = write operand, 0 = read
//                matDecide  engine -> responder, 0 = A, 1 = B (writes only)
//                dataInBus  engine -> responder, packed operand matrix
//                dataOut    responder -> engine, packed product matrix
//                fleg       responder -> engine, one-cycle completion pulse
//                busy       responder -> engine, high outside IDLE
//  Revision    : 1.0  initial release
// ============================================================================
interface matmul_responder_if #(
    parameter int BUS_W = 256
);
    logic             enable;
    logic             RW;
    logic             matDecide;
    logic [BUS_W-1:0] dataInBus;
    logic [BUS_W-1:0] dataOut;
    logic             fleg;
    logic             busy;

    modport master (
        output enable,
        output RW,
        output matDecide,
        output dataInBus,
        input  dataOut,
        input  fleg,
        input  busy
    );

    modport slave (
        input  enable,
        input  RW,
        input  matDecide,
        input  dataInBus,
        output dataOut,
        output fleg,
        output busy
    );
endinterface
`default_nettype wire

// File: rtl/matmul_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : matmul_responder
//  Description : Responder for the engine's enable/RW/matDecide/fleg
//                handshake. Writes latch operand A or B. A read computes
//                C = A x B with one multiply-accumulate per clock (DIM^3
//                cycles). It then presents C on dataOut and pulses fleg.
//  Ports       : clk    system clock, rising edge
//                RESET  asynchronous, active-low reset
//                bus    matmul_responder_if.slave (enable, RW, matDecide,
//                       dataInBus in; dataOut, fleg, busy out)
//  Options     : MATMUL_SAT_EN defined   -> product elements saturate at
//                                           all-ones
//                MATMUL_SAT_EN undefined -> product elements wrap modulo
//                                           2^ELEM_W
//  Revision    : 1.0  initial release
// ============================================================================
module matmul_responder #(
    parameter int ELEM_W = 16,
    parameter int DIM    = 4,     // only 4 is supported
    parameter int ACC_W  = 34     // >= 2*ELEM_W + 2
) (
    input  wire logic         clk,
    input  wire logic         RESET,
    matmul_responder_if.slave bus
);
    localparam int BUS_W  = DIM * DIM * ELEM_W;
    localparam int IDX_W  = $clog2(DIM);
    localparam int STEP_W = 3 * IDX_W;
    localparam int PROD_W = 2 * ELEM_W;
    localparam logic [IDX_W-1:0]  LAST_P    = '1;
    localparam logic [STEP_W-1:0] LAST_STEP = '1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK     = 3'd1,
        COMPUTE = 3'd2,
        DONE    = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t state;
    state_t state_next;

    logic [BUS_W-1:0]  a_mat;
    logic [BUS_W-1:0]  b_mat;
    logic [BUS_W-1:0]  c_mat;
    logic [BUS_W-1:0]  dout_q;
    logic [ACC_W-1:0]  acc;
    logic [STEP_W-1:0] step;
    logic              fleg_q;
    logic              busy_q;

    // The step counter walks row-major over C. The inner product index
    // occupies the low bits, so each C element takes DIM consecutive steps.
    logic [IDX_W-1:0]  row;
    logic [IDX_W-1:0]  col;
    logic [IDX_W-1:0]  p_idx;
    logic [ELEM_W-1:0] a_elem;
    logic [ELEM_W-1:0] b_elem;
    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  mac_sum;

    assign row    = step[STEP_W-1 -: IDX_W];
    assign col    = step[2*IDX_W-1 -: IDX_W];
    assign p_idx  = step[IDX_W-1:0];
    assign a_elem = a_mat[(int'(row)   * DIM + int'(p_idx)) * ELEM_W +: ELEM_W];
    assign b_elem = b_mat[(int'(p_idx) * DIM + int'(col))   * ELEM_W +: ELEM_W];
    assign prod   = PROD_W'(a_elem) * PROD_W'(b_elem);

    // The first term of each inner product restarts the sum, so the
    // accumulator never needs an explicit clear between C elements.
    assign mac_sum = ((p_idx == '0) ? '0 : acc) + ACC_W'(prod);

    // Narrow a finished inner product to one C element.
    function automatic logic [ELEM_W-1:0] reduce_elem(input logic [ACC_W-1:0] v);
`ifdef MATMUL_SAT_EN
        return (|v[ACC_W-1:ELEM_W]) ? {ELEM_W{1'b1}} : v[ELEM_W-1:0];
`else
        return v[ELEM_W-1:0];
`endif
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_next = bus.RW ? ACK : COMPUTE;
                end
            end
            ACK:     state_next = RELEASE;
            COMPUTE: begin
                if (step == LAST_STEP) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = RELEASE;
            // Wait for the engine to drop enable. This keeps a held
            // request from being accepted a second time.
            RELEASE: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            a_mat  <= '0;
            b_mat  <= '0;
            c_mat  <= '0;
            dout_q <= '0;
            acc    <= '0;
            step   <= '0;
            fleg_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            // fleg is high for exactly the cycle after ACK or DONE. Both
            // states always move to RELEASE, so the pulse clears itself.
            fleg_q <= (state == ACK) || (state == DONE);
            busy_q <= (state_next != IDLE);

            unique case (state)
                IDLE: begin
                    if (bus.enable) begin
                        if (bus.RW) begin
                            if (bus.matDecide) begin
                                b_mat <= bus.dataInBus;
                            end else begin
                                a_mat <= bus.dataInBus;
                            end
                        end else begin
                            step <= '0;
                            acc  <= '0;
                        end
                    end
                end
                COMPUTE: begin
                    acc  <= mac_sum;
                    step <= step + STEP_W'(1);
                    if (p_idx == LAST_P) begin
                        c_mat[(int'(row) * DIM + int'(col)) * ELEM_W +: ELEM_W]
                            <= reduce_elem(mac_sum);
                    end
                end
                DONE: begin
                    dout_q <= c_mat;
                end
                default: ;
            endcase
        end
    end

    assign bus.dataOut = dout_q;
    assign bus.fleg    = fleg_q;
    assign bus.busy    = busy_q;
endmodule
`default_nettype wire
